// File: rtl/inst_buffer_pkg.sv
// rtl/inst_buffer_pkg.sv - shared fetch packet types and width constants
package inst_buffer_pkg;

   localparam int N                 = 3;
   localparam int NUM_SCALAR_BITS   = $clog2(N + 1);
   localparam int INST_BUFFER_DEPTH = 16;

   typedef logic [31:0] INST;
   typedef logic [31:0] ADDR;

   typedef struct packed {
      INST  inst;
      ADDR  PC;
      logic taken;
   } FETCH_PACKET;

   // Saturates an entry count to the superscalar width.
   function automatic logic [NUM_SCALAR_BITS-1:0] clamp_to_n(input int unsigned a);
      return (a > int'(N)) ? NUM_SCALAR_BITS'(N) : NUM_SCALAR_BITS'(a);
   endfunction

endpackage

// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - circular packet FIFO between Fetch and Dispatch
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH = INST_BUFFER_DEPTH
)
(
   input  logic                       clock,
   input  logic                       reset,
   input  FETCH_PACKET [N-1:0]        inst_buffer_inputs,
   input  logic [NUM_SCALAR_BITS-1:0] instructions_valid,
   output logic [NUM_SCALAR_BITS-1:0] inst_buffer_spots,
   input  logic                       restore_valid,
   output FETCH_PACKET [N-1:0]        dispatch_packets,
   output logic [NUM_SCALAR_BITS-1:0] dispatch_avail,
   input  logic [NUM_SCALAR_BITS-1:0] dispatch_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0]           head;
   logic [PTR_W-1:0]           tail;
   logic [CNT_W-1:0]           count;
   FETCH_PACKET                storage [DEPTH];
   logic [NUM_SCALAR_BITS-1:0] wr_num;
   logic [NUM_SCALAR_BITS-1:0] rd_num;

   // Free space and occupancy come from start-of-cycle count only.
   always_comb begin
      inst_buffer_spots = clamp_to_n(32'(CNT_W'(DEPTH) - count));
      dispatch_avail    = clamp_to_n(32'(count));
      wr_num = (instructions_valid < inst_buffer_spots) ? instructions_valid : inst_buffer_spots;
      rd_num = (dispatch_count < dispatch_avail) ? dispatch_count : dispatch_avail;
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         dispatch_packets[i] = '0;
         if (NUM_SCALAR_BITS'(i) < dispatch_avail)
            dispatch_packets[i] = storage[head + PTR_W'(i)];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int j = 0; j < DEPTH; j++)
            storage[j] <= '0;
      end else if (!restore_valid) begin
         for (int i = 0; i < N; i++) begin
            if (NUM_SCALAR_BITS'(i) < wr_num)
               storage[tail + PTR_W'(i)] <= inst_buffer_inputs[i];
         end
      end
   end

   // Full versus empty is decided by count; head == tail is ambiguous.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (restore_valid) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(rd_num);
         tail  <= tail + PTR_W'(wr_num);
         count <= count + CNT_W'(wr_num) - CNT_W'(rd_num);
      end
   end

   a_write_fits: assert property (@(posedge clock) disable iff (!reset || restore_valid)
      (instructions_valid <= inst_buffer_spots))
      else $warning("inst_buffer: instructions_valid exceeds inst_buffer_spots, excess dropped");

   a_read_fits: assert property (@(posedge clock) disable iff (!reset || restore_valid)
      (dispatch_count <= dispatch_avail))
      else $warning("inst_buffer: dispatch_count exceeds dispatch_avail, read clamped");

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - directed self-checking bench for inst_buffer
module tb_inst_buffer;
   import inst_buffer_pkg::*;

   localparam int DEPTH = 8;

   logic                       clock = 1'b0;
   logic                       reset;
   FETCH_PACKET [N-1:0]        inst_buffer_inputs;
   logic [NUM_SCALAR_BITS-1:0] instructions_valid;
   logic [NUM_SCALAR_BITS-1:0] inst_buffer_spots;
   logic                       restore_valid;
   FETCH_PACKET [N-1:0]        dispatch_packets;
   logic [NUM_SCALAR_BITS-1:0] dispatch_avail;
   logic [NUM_SCALAR_BITS-1:0] dispatch_count;

   int tests = 0;
   int fails = 0;

   inst_buffer #(.DEPTH(DEPTH)) dut (
      .clock              (clock),
      .reset              (reset),
      .inst_buffer_inputs (inst_buffer_inputs),
      .instructions_valid (instructions_valid),
      .inst_buffer_spots  (inst_buffer_spots),
      .restore_valid      (restore_valid),
      .dispatch_packets   (dispatch_packets),
      .dispatch_avail     (dispatch_avail),
      .dispatch_count     (dispatch_count)
   );

   always #5 clock = ~clock;

   function automatic FETCH_PACKET mk(input logic [31:0] pc);
      FETCH_PACKET p;
      p.inst  = pc ^ 32'h0013_0013;
      p.PC    = pc;
      p.taken = pc[2];
      return p;
   endfunction

   // Expected dispatch vector: first n slots hold the given PCs, the rest '0.
   function automatic FETCH_PACKET [N-1:0] exp_pk(input int n, input logic [31:0] p0,
                                                  input logic [31:0] p1, input logic [31:0] p2);
      FETCH_PACKET [N-1:0] e;
      e = '0;
      if (n > 0) e[0] = mk(p0);
      if (n > 1) e[1] = mk(p1);
      if (n > 2) e[2] = mk(p2);
      return e;
   endfunction

   task automatic drive(input int n, input logic [31:0] pc0, input int rd);
      inst_buffer_inputs = '0;
      for (int i = 0; i < N; i++)
         if (i < n) inst_buffer_inputs[i] = mk(pc0 + 32'(4 * i));
      instructions_valid = NUM_SCALAR_BITS'(n);
      dispatch_count     = NUM_SCALAR_BITS'(rd);
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      restore_valid = 1'b0;
      drive(0, 0, 0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
      if (inst_buffer_spots !== 2'd3) begin fails++; $display("FAIL reset_spots: got %0d want 3", inst_buffer_spots); end
      tests++;
      if (dispatch_avail !== 2'd0) begin fails++; $display("FAIL reset_avail: got %0d want 0", dispatch_avail); end
      tests++;
      drive(3, 32'h500, 0);
      step();
      drive(0, 0, 0);
      if (dispatch_avail !== 2'd3) begin fails++; $display("FAIL prereset_avail: got %0d want 3", dispatch_avail); end
      tests++;
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      if (inst_buffer_spots !== 2'd3) begin fails++; $display("FAIL async_reset_spots: got %0d want 3", inst_buffer_spots); end
      tests++;
      if (dispatch_avail !== 2'd0) begin fails++; $display("FAIL async_reset_avail: got %0d want 0", dispatch_avail); end
      tests++;
      if (dispatch_packets !== '0) begin fails++; $display("FAIL async_reset_packets: got %h want 0", dispatch_packets); end
      tests++;
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_in_order;
      drive(3, 32'h0, 0);
      step();
      drive(0, 0, 0);
      if (dispatch_avail !== 2'd3) begin fails++; $display("FAIL in_order_avail: got %0d want 3", dispatch_avail); end
      tests++;
      if (dispatch_packets !== exp_pk(3, 32'h0, 32'h4, 32'h8)) begin
         fails++; $display("FAIL in_order_packets: got %h want %h", dispatch_packets, exp_pk(3, 32'h0, 32'h4, 32'h8));
      end
      tests++;
      if (inst_buffer_spots !== 2'd3) begin fails++; $display("FAIL in_order_spots: got %0d want 3", inst_buffer_spots); end
      tests++;
   endtask

   task automatic test_fill_full;
      restore_valid = 1'b1;
      step();
      restore_valid = 1'b0;
      if (inst_buffer_spots !== 2'd3) begin fails++; $display("FAIL fill_spots0: got %0d want 3", inst_buffer_spots); end
      tests++;
      drive(3, 32'h100, 0);
      step();
      if (inst_buffer_spots !== 2'd3) begin fails++; $display("FAIL fill_spots1: got %0d want 3", inst_buffer_spots); end
      tests++;
      drive(3, 32'h10c, 0);
      step();
      if (inst_buffer_spots !== 2'd2) begin fails++; $display("FAIL fill_spots2: got %0d want 2", inst_buffer_spots); end
      tests++;
      drive(2, 32'h118, 0);
      step();
      if (inst_buffer_spots !== 2'd0) begin fails++; $display("FAIL fill_spots3: got %0d want 0", inst_buffer_spots); end
      tests++;
      drive(2, 32'h900, 0);
      step();
      drive(0, 0, 0);
      if (inst_buffer_spots !== 2'd0) begin fails++; $display("FAIL full_spots: got %0d want 0", inst_buffer_spots); end
      tests++;
      if (dispatch_packets !== exp_pk(3, 32'h100, 32'h104, 32'h108)) begin
         fails++; $display("FAIL full_packets: got %h want %h", dispatch_packets, exp_pk(3, 32'h100, 32'h104, 32'h108));
      end
      tests++;
      drive(0, 0, 3);
      step();
      if (dispatch_packets !== exp_pk(3, 32'h10c, 32'h110, 32'h114)) begin
         fails++; $display("FAIL drain1_packets: got %h want %h", dispatch_packets, exp_pk(3, 32'h10c, 32'h110, 32'h114));
      end
      tests++;
      step();
      drive(0, 0, 0);
      if (dispatch_avail !== 2'd2) begin fails++; $display("FAIL drain2_avail: got %0d want 2 (overflow not dropped)", dispatch_avail); end
      tests++;
      if (dispatch_packets !== exp_pk(2, 32'h118, 32'h11c, 0)) begin
         fails++; $display("FAIL drain2_packets: got %h want %h", dispatch_packets, exp_pk(2, 32'h118, 32'h11c, 0));
      end
      tests++;
   endtask

   task automatic test_wrap_simultaneous;
      drive(3, 32'h200, 0);
      step();
      drive(1, 32'h20c, 0);
      step();
      if (inst_buffer_spots !== 2'd2) begin fails++; $display("FAIL wrap_spots_pre: got %0d want 2", inst_buffer_spots); end
      tests++;
      if (dispatch_packets !== exp_pk(3, 32'h118, 32'h11c, 32'h200)) begin
         fails++; $display("FAIL wrap_boundary_packets: got %h want %h", dispatch_packets, exp_pk(3, 32'h118, 32'h11c, 32'h200));
      end
      tests++;
      drive(2, 32'h210, 3);
      step();
      drive(0, 0, 0);
      if (dispatch_packets !== exp_pk(3, 32'h204, 32'h208, 32'h20c)) begin
         fails++; $display("FAIL simul_packets: got %h want %h", dispatch_packets, exp_pk(3, 32'h204, 32'h208, 32'h20c));
      end
      tests++;
      if (inst_buffer_spots !== 2'd3) begin fails++; $display("FAIL simul_spots: got %0d want 3", inst_buffer_spots); end
      tests++;
      drive(0, 0, 3);
      step();
      drive(0, 0, 0);
      if (dispatch_packets !== exp_pk(2, 32'h210, 32'h214, 0)) begin
         fails++; $display("FAIL simul_tail_packets: got %h want %h", dispatch_packets, exp_pk(2, 32'h210, 32'h214, 0));
      end
      tests++;
   endtask

   task automatic test_clamped_read;
      drive(0, 0, 3);
      step();
      drive(0, 0, 0);
      if (dispatch_avail !== 2'd0) begin fails++; $display("FAIL clamp_avail: got %0d want 0", dispatch_avail); end
      tests++;
      if (inst_buffer_spots !== 2'd3) begin fails++; $display("FAIL clamp_spots: got %0d want 3", inst_buffer_spots); end
      tests++;
      if (dispatch_packets !== '0) begin fails++; $display("FAIL clamp_packets: got %h want 0", dispatch_packets); end
      tests++;
   endtask

   task automatic test_flush;
      drive(3, 32'h300, 0);
      step();
      drive(2, 32'h30c, 0);
      step();
      if (dispatch_avail !== 2'd3) begin fails++; $display("FAIL flush_pre_avail: got %0d want 3", dispatch_avail); end
      tests++;
      drive(3, 32'h800, 2);
      restore_valid = 1'b1;
      step();
      restore_valid = 1'b0;
      drive(0, 0, 0);
      if (dispatch_avail !== 2'd0) begin fails++; $display("FAIL flush_avail: got %0d want 0", dispatch_avail); end
      tests++;
      if (inst_buffer_spots !== 2'd3) begin fails++; $display("FAIL flush_spots: got %0d want 3", inst_buffer_spots); end
      tests++;
      drive(1, 32'h40, 0);
      step();
      drive(0, 0, 0);
      if (dispatch_avail !== 2'd1) begin fails++; $display("FAIL refill_avail: got %0d want 1", dispatch_avail); end
      tests++;
      if (dispatch_packets !== exp_pk(1, 32'h40, 0, 0)) begin
         fails++; $display("FAIL refill_packets: got %h want %h", dispatch_packets, exp_pk(1, 32'h40, 0, 0));
      end
      tests++;
   endtask

   initial begin
      test_reset();
      test_in_order();
      test_fill_full();
      test_wrap_simultaneous();
      test_clamped_read();
      test_flush();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got stall want completion");
      $fatal(1);
   end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
Circular FIFO between the Fetch stage and Dispatch. It accepts up to N FETCH_PACKETs per cycle from Fetch and advertises its free space back to Fetch. It presents up to N oldest packets per cycle to Dispatch, which pops a chosen count. Fetch sizes its output from inst_buffer_spots. A branch restore flushes the buffer so it can be refilled from the restored PC.

Parameters:
N, `N (sys_defs), superscalar width: packets written/read per cycle
DEPTH, 16, number of entries; power of two, DEPTH >= N

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
inst_buffer_inputs  in  N x FETCH_PACKET  packets from Fetch, oldest in [0]
instructions_valid  in  NUM_SCALAR_BITS  number of valid packets in inst_buffer_inputs
inst_buffer_spots  out  NUM_SCALAR_BITS  min(free entries, N), to Fetch
restore_valid  in  1  flush request (branch restore / mispredict)
dispatch_packets  out  N x FETCH_PACKET  oldest entries, oldest in [0]; unused slots '0
dispatch_avail  out  NUM_SCALAR_BITS  min(occupied entries, N)
dispatch_count  in  NUM_SCALAR_BITS  number of packets Dispatch consumes this cycle

Behaviour:
- State: head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; count of $clog2(DEPTH+1) bits; storage DEPTH x FETCH_PACKET.
- All outputs are combinational from registered state only. No input-to-output combinational path, so Fetch and Dispatch can use them in the same cycle.
- inst_buffer_spots = min(DEPTH-count, N).
- dispatch_avail = min(count, N).
- dispatch_packets[i] = storage[(head+i) mod DEPTH] for i < dispatch_avail, else '0.
- Write: wr = min(instructions_valid, inst_buffer_spots). Entries inst_buffer_inputs[0..wr-1] go to storage[tail..tail+wr-1] (mod DEPTH). tail advances by wr. Excess packets beyond spots are dropped; a simulation assertion flags instructions_valid > inst_buffer_spots.
- Read: rd = min(dispatch_count, dispatch_avail). head advances by rd. An assertion flags dispatch_count > dispatch_avail.
- count_next = count + wr - rd.
  - Simultaneous read and write in one cycle is legal.
  - Spots are based on start-of-cycle count, so entries freed by this cycle's read become visible next cycle. The buffer can therefore never overflow.
- Latency: a packet written at edge k is visible on dispatch_packets in cycle k+1. There is no bypass from write to read within a cycle.
- Flush: restore_valid=1 takes priority over read and write.
  - Next edge: head=tail=count=0; that cycle's writes and reads are discarded.
  - Storage contents need not be cleared.
  - The cycle after the flush: spots=min(DEPTH,N), avail=0.
- Reset (reset=0, asynchronous): head=tail=count=0, storage cleared to '0, immediately and independent of clock.
  - Outputs during and after reset: inst_buffer_spots=min(DEPTH,N), dispatch_avail=0, dispatch_packets='0.
  - Deassertion is synchronous to clock in the reset synchronizer upstream; the block samples normally from the first rising edge after release.
- Wrap-around: pointer arithmetic is modulo DEPTH. Full (count=DEPTH) and empty (count=0) are distinguished by count, never by pointer equality.

Decomposition:
- Shared package / sys_defs.svh: FETCH_PACKET {INST inst; ADDR PC; logic taken;}, `N, NUM_SCALAR_BITS = $clog2(N+1), INST_BUFFER_DEPTH.
- The block is a single module. An optional helper function computes min(a,N) for the spots and avail clamps. No sub-module is required.

Test Plan (N=3, DEPTH=8):
- Reset: drive reset=0 mid-cycle -> spots=3, avail=0, packets all '0 immediately, without waiting for a clock edge.
- In-order delivery: write 3 packets PC 0x0,0x4,0x8 with dispatch_count=0 -> next cycle avail=3, packets[0..2].PC=0x0,0x4,0x8, spots=3.
- Fill/full: writes of 3,3,2 with no reads -> spots 3,3,2,0 and count 8; then instructions_valid=2 -> nothing written, count stays 8, assertion fires.
- Wrap and simultaneous: at head=6, count=6, write 2 and read 3 in one cycle -> count 5, head=1, tail=6. Packets present in order across the index 7->0 boundary.
- Flush: count=5, restore_valid=1 with instructions_valid=3 and dispatch_count=2 -> next cycle avail=0, spots=3. Next write PC 0x40 appears at packets[0] one cycle later.
- Clamped read: count=2, dispatch_count=3 -> only 2 popped, count 0, assertion fires, avail=0 next cycle.
